// File: rtl/bus_stim_gen.sv
// ---------------------------------------------------------------------------
// bus_stim_gen
//
// Programmable burst sequencer that produces addr/en/wr/wdata stimulus for a
// simple en/wr memory-style slave. Test-control logic supplies a burst
// description (mode, base address, length, inter-beat gap, data seed) and
// pulses start; the block then drives one beat at a time, honouring slave
// back-pressure through ready.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a sequence (only looked at while idle)
//   abort      in   synchronous abort, wins over everything else
//   mode       in   00 write burst, 01 read burst, 10 write-then-read,
//                   11 alternating write/read per beat
//   base_addr  in   address of the first beat
//   len        in   beats per phase minus one
//   gap        in   idle cycles (en=0) between beats
//   data_seed  in   write data of the first write beat
//   ready      in   slave accepts the current beat
//   addr       out  beat address
//   en         out  beat valid
//   wr         out  1 = write, 0 = read
//   wdata      out  write data, 0 on read beats
//   busy       out  sequence in progress
//   done       out  one-cycle completion pulse
//   beat_cnt   out  beats accepted in the current sequence
//
// Build option:
//   BUS_STIM_GEN_LFSR_DATA_EN - when defined, write data comes from a
//   Fibonacci LFSR loaded with data_seed (0 replaced by all-ones) instead of
//   the incrementing data_seed + write-beat-index pattern.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module bus_stim_gen #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4,
    parameter int GAP_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [GAP_W-1:0]  gap,
    input  logic [DATA_W-1:0] data_seed,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              en,
    output logic              wr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [LEN_W:0]    beat_cnt
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_BEAT = 3'd1;
    localparam logic [2:0] ST_GAP  = 3'd2;
    localparam logic [2:0] ST_TURN = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [1:0] MODE_WR  = 2'b00;
    localparam logic [1:0] MODE_RD  = 2'b01;
    localparam logic [1:0] MODE_WTR = 2'b10;
    localparam logic [1:0] MODE_ALT = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]    CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]  GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

`ifdef BUS_STIM_GEN_LFSR_DATA_EN
    // Tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3); other widths fall back
    // to a simple end-around tap pair.
    localparam logic [DATA_W-1:0] LFSR_TAPS = (DATA_W == 8) ?
        DATA_W'(8'hB8) : {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
`else
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
`endif

    // Value loaded into the write-data generator when a sequence starts.
    function automatic logic [DATA_W-1:0] wval_seed(input logic [DATA_W-1:0] s);
`ifdef BUS_STIM_GEN_LFSR_DATA_EN
        // An all-zero LFSR would lock up, so zero is replaced by all-ones.
        if (s == DATA_ZERO) begin
            wval_seed = {DATA_W{1'b1}};
        end else begin
            wval_seed = s;
        end
`else
        wval_seed = s;
`endif
    endfunction

    // Write data for the write beat that follows one carrying v.
    function automatic logic [DATA_W-1:0] wval_step(input logic [DATA_W-1:0] v);
`ifdef BUS_STIM_GEN_LFSR_DATA_EN
        wval_step = {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
`else
        wval_step = v + DATA_ONE;
`endif
    endfunction

    // Direction of the next beat inside a phase.
    function automatic logic next_wr(input logic [1:0] m, input logic read_phase,
                                     input logic cur_wr);
        case (m)
            MODE_WR:  next_wr = 1'b1;
            MODE_RD:  next_wr = 1'b0;
            MODE_WTR: next_wr = ~read_phase;
            MODE_ALT: next_wr = ~cur_wr;
            default:  next_wr = 1'b0;
        endcase
    endfunction

    // Output flops
    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic              en_q,        en_d;
    logic              wr_q,        wr_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [LEN_W:0]    beat_cnt_q,  beat_cnt_d;

    // Latched burst description and sequencing state
    logic [ADDR_W-1:0] base_q,      base_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [GAP_W-1:0]  gap_q,       gap_d;
    logic [1:0]        mode_q,      mode_d;
    logic [DATA_W-1:0] wval_q,      wval_d;      // data of current/next write beat
    logic [LEN_W-1:0]  phase_idx_q, phase_idx_d; // beat index within phase
    logic              phase_q,     phase_d;     // 1 = read phase of mode 10
    logic [GAP_W-1:0]  gap_cnt_q,   gap_cnt_d;

    logic              last_in_phase_s;
    logic              last_overall_s;
    logic              nxt_wr_s;

    // Decode where the current beat sits in the sequence.
    always_comb begin
        last_in_phase_s = (phase_idx_q == len_q);
        last_overall_s  = last_in_phase_s && ((mode_q != MODE_WTR) || phase_q);
        nxt_wr_s        = next_wr(mode_q, phase_q, wr_q);
    end

    // Sequencer next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        en_d        = en_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        beat_cnt_d  = beat_cnt_q;
        base_d      = base_q;
        len_d       = len_q;
        gap_d       = gap_q;
        mode_d      = mode_q;
        wval_d      = wval_q;
        phase_idx_d = phase_idx_q;
        phase_d     = phase_q;
        gap_cnt_d   = gap_cnt_q;

        if (abort) begin
            // Abort beats everything, including a beat accepted this edge.
            state_d = ST_IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                    if (start) begin
                        base_d      = base_addr;
                        len_d       = len;
                        gap_d       = gap;
                        mode_d      = mode;
                        wval_d      = wval_seed(data_seed);
                        phase_idx_d = {LEN_W{1'b0}};
                        phase_d     = 1'b0;
                        beat_cnt_d  = {(LEN_W+1){1'b0}};
                        addr_d      = base_addr;
                        // Every mode except pure read opens with a write.
                        wr_d        = (mode != MODE_RD);
                        wdata_d     = (mode != MODE_RD) ? wval_seed(data_seed) : DATA_ZERO;
                        en_d        = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = ST_BEAT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_BEAT: begin
                    if (ready) begin
                        beat_cnt_d = beat_cnt_q + CNT_ONE;
                        if (wr_q) begin
                            wval_d = wval_step(wval_q);
                        end else begin
                            wval_d = wval_q;
                        end
                        if (last_overall_s) begin
                            state_d = ST_DONE;
                            en_d    = 1'b0;
                            done_d  = 1'b1;
                        end else if (last_in_phase_s) begin
                            // End of the write phase in mode 10: one turnaround
                            // cycle, then reads restart from the base address.
                            state_d     = ST_TURN;
                            en_d        = 1'b0;
                            phase_d     = 1'b1;
                            phase_idx_d = {LEN_W{1'b0}};
                            addr_d      = base_q;
                            wr_d        = 1'b0;
                            wdata_d     = DATA_ZERO;
                        end else begin
                            // Next beat values are loaded now; during a gap
                            // they are simply masked by en=0.
                            phase_idx_d = phase_idx_q + LEN_ONE;
                            addr_d      = addr_q + ADDR_ONE;
                            wr_d        = nxt_wr_s;
                            wdata_d     = nxt_wr_s ? wval_d : DATA_ZERO;
                            if (gap_q != {GAP_W{1'b0}}) begin
                                state_d   = ST_GAP;
                                en_d      = 1'b0;
                                gap_cnt_d = gap_q - GAP_ONE;
                            end else begin
                                state_d = ST_BEAT;
                                en_d    = 1'b1;
                            end
                        end
                    end else begin
                        state_d = ST_BEAT;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_q == {GAP_W{1'b0}}) begin
                        state_d = ST_BEAT;
                        en_d    = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end
                end

                ST_TURN: begin
                    state_d = ST_BEAT;
                    en_d    = 1'b1;
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end

                default: begin
                    state_d = ST_IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            en_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= DATA_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            beat_cnt_q  <= {(LEN_W+1){1'b0}};
            base_q      <= {ADDR_W{1'b0}};
            len_q       <= {LEN_W{1'b0}};
            gap_q       <= {GAP_W{1'b0}};
            mode_q      <= 2'b00;
            wval_q      <= DATA_ZERO;
            phase_idx_q <= {LEN_W{1'b0}};
            phase_q     <= 1'b0;
            gap_cnt_q   <= {GAP_W{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            beat_cnt_q  <= beat_cnt_d;
            base_q      <= base_d;
            len_q       <= len_d;
            gap_q       <= gap_d;
            mode_q      <= mode_d;
            wval_q      <= wval_d;
            phase_idx_q <= phase_idx_d;
            phase_q     <= phase_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign addr     = addr_q;
    assign en       = en_q;
    assign wr       = wr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_bus_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_bus_stim_gen
//
// Directed testbench for bus_stim_gen with default parameters. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the
// same point, so each observation reflects the edge just passed.
// ---------------------------------------------------------------------------
module tb_bus_stim_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [5:0] base_addr;
    logic [3:0] len;
    logic [2:0] gap;
    logic [7:0] data_seed;
    logic       ready;
    logic [5:0] addr;
    logic       en;
    logic       wr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [4:0] beat_cnt;

    int n_cmp = 0;
    int n_err = 0;

    bus_stim_gen #(
        .ADDR_W(6), .DATA_W(8), .LEN_W(4), .GAP_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .base_addr(base_addr), .len(len), .gap(gap), .data_seed(data_seed),
        .ready(ready), .addr(addr), .en(en), .wr(wr), .wdata(wdata),
        .busy(busy), .done(done), .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [5:0] b,
                            input logic [3:0] l, input logic [2:0] g,
                            input logic [7:0] s);
        mode = m; base_addr = b; len = l; gap = g; data_seed = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00;
        base_addr = 6'h00; len = 4'h0; gap = 3'h0; data_seed = 8'h00; ready = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({addr, en, wr, wdata, busy, done, beat_cnt} !== 25'd0) begin
            n_err++;
            $display("FAIL reset_state: got addr=%h en=%b wr=%b wdata=%h busy=%b done=%b cnt=%0d, want all 0",
                     addr, en, wr, wdata, busy, done, beat_cnt);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({en, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release_idle: got en=%b busy=%b done=%b, want 000", en, busy, done);
        end
    endtask

    task automatic test_write_burst();
        logic [5:0] ea;
        logic [7:0] ed;
        ready = 1'b1;
        do_start(2'b00, 6'h0C, 4'd3, 3'd0, 8'hA0);
        for (int i = 0; i < 4; i++) begin
            ea = 6'h0C + i[5:0];
            ed = 8'hA0 + i[7:0];
            n_cmp++;
            if ({en, wr, busy, done, addr, wdata} !== {4'b1110, ea, ed}) begin
                n_err++;
                $display("FAIL wr_burst_beat%0d: got en=%b wr=%b busy=%b done=%b addr=%h wdata=%h, want en=1 wr=1 busy=1 done=0 addr=%h wdata=%h",
                         i, en, wr, busy, done, addr, wdata, ea, ed);
            end
            // A start pulse mid-burst must be ignored.
            if (i == 1) begin
                start = 1'b1; mode = 2'b01; base_addr = 6'h00;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if ({en, busy, done, beat_cnt} !== {3'b011, 5'd4}) begin
            n_err++;
            $display("FAIL wr_burst_done: got en=%b busy=%b done=%b cnt=%0d, want en=0 busy=1 done=1 cnt=4",
                     en, busy, done, beat_cnt);
        end
        tick();
        n_cmp++;
        if ({en, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL wr_burst_idle: got en=%b busy=%b done=%b, want 000", en, busy, done);
        end
    endtask

    task automatic test_write_read();
        int e_en [12];
        int e_wr [12];
        int e_ad [12];
        int e_wd [12];
        e_en = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        e_wr = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        e_ad = '{'h3E, 0, 'h3F, 0, 'h00, 0, 'h3E, 0, 'h3F, 0, 'h00, 0};
        e_wd = '{'h10, 0, 'h11, 0, 'h12, 0, 0, 0, 0, 0, 0, 0};
        ready = 1'b1;
        do_start(2'b10, 6'h3E, 4'd2, 3'd1, 8'h10);
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (e_en[i] == 1) begin
                if ({en, wr, busy, done, addr, wdata} !==
                    {1'b1, e_wr[i][0], 2'b10, e_ad[i][5:0], e_wd[i][7:0]}) begin
                    n_err++;
                    $display("FAIL wtr_cycle%0d: got en=%b wr=%b busy=%b done=%b addr=%h wdata=%h, want en=1 wr=%0d addr=%h wdata=%h",
                             i, en, wr, busy, done, addr, wdata, e_wr[i], e_ad[i], e_wd[i]);
                end
            end else begin
                if ({en, busy, done} !== {2'b01, (i == 11)}) begin
                    n_err++;
                    $display("FAIL wtr_idle%0d: got en=%b busy=%b done=%b, want en=0 busy=1 done=%0d",
                             i, en, busy, done, (i == 11));
                end
            end
            if (i == 11) begin
                n_cmp++;
                if (beat_cnt !== 5'd6) begin
                    n_err++;
                    $display("FAIL wtr_count: got %0d, want 6", beat_cnt);
                end
            end else begin
                n_cmp = n_cmp;
            end
            tick();
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wtr_idle_after: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        do_start(2'b01, 6'h05, 4'd1, 3'd0, 8'h77);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({en, wr, addr, wdata, beat_cnt} !== {2'b10, 6'h05, 8'h00, 5'd0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got en=%b wr=%b addr=%h wdata=%h cnt=%0d, want en=1 wr=0 addr=05 wdata=00 cnt=0",
                         i, en, wr, addr, wdata, beat_cnt);
            end
            if (i == 3) begin
                ready = 1'b1;
            end else begin
                ready = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if ({en, wr, addr, beat_cnt} !== {2'b10, 6'h06, 5'd1}) begin
            n_err++;
            $display("FAIL bp_beat2: got en=%b wr=%b addr=%h cnt=%0d, want en=1 wr=0 addr=06 cnt=1",
                     en, wr, addr, beat_cnt);
        end
        tick();
        n_cmp++;
        if ({en, done, beat_cnt} !== {2'b01, 5'd2}) begin
            n_err++;
            $display("FAIL bp_done: got en=%b done=%b cnt=%0d, want en=0 done=1 cnt=2", en, done, beat_cnt);
        end
        tick();
    endtask

    task automatic test_alternate();
        logic [5:0]  ea;
        logic [7:0]  ed;
        logic        ew;
        ready = 1'b1;
        do_start(2'b11, 6'h17, 4'd3, 3'd0, 8'h55);
        for (int i = 0; i < 4; i++) begin
            ea = 6'h17 + i[5:0];
            ew = (i % 2 == 0);
            ed = ew ? (8'h55 + 8'(i / 2)) : 8'h00;
            n_cmp++;
            if ({en, wr, addr, wdata} !== {1'b1, ew, ea, ed}) begin
                n_err++;
                $display("FAIL alt_beat%0d: got en=%b wr=%b addr=%h wdata=%h, want en=1 wr=%b addr=%h wdata=%h",
                         i, en, wr, addr, wdata, ew, ea, ed);
            end
            tick();
        end
        n_cmp++;
        if ({done, beat_cnt} !== {1'b1, 5'd4}) begin
            n_err++;
            $display("FAIL alt_done: got done=%b cnt=%0d, want done=1 cnt=4", done, beat_cnt);
        end
        tick();
    endtask

    task automatic test_max_len();
        logic [5:0] ea;
        logic [7:0] ed;
        int         bad;
        ready = 1'b1;
        bad = 0;
        do_start(2'b00, 6'h3A, 4'hF, 3'd0, 8'hFE);
        for (int i = 0; i < 16; i++) begin
            ea = 6'h3A + i[5:0];
            ed = 8'hFE + i[7:0];
            n_cmp++;
            if ({en, wr, addr, wdata} !== {2'b11, ea, ed}) begin
                n_err++;
                $display("FAIL maxlen_beat%0d: got en=%b wr=%b addr=%h wdata=%h, want en=1 wr=1 addr=%h wdata=%h",
                         i, en, wr, addr, wdata, ea, ed);
            end
            tick();
        end
        n_cmp++;
        if ({done, beat_cnt} !== {1'b1, 5'd16}) begin
            n_err++;
            $display("FAIL maxlen_done: got done=%b cnt=%0d, want done=1 cnt=16", done, beat_cnt);
        end
        tick();
        // len=0 gives exactly one beat.
        do_start(2'b00, 6'h10, 4'd0, 3'd2, 8'h33);
        n_cmp++;
        if ({en, addr, wdata} !== {1'b1, 6'h10, 8'h33}) begin
            n_err++;
            $display("FAIL single_beat: got en=%b addr=%h wdata=%h, want en=1 addr=10 wdata=33", en, addr, wdata);
        end
        tick();
        n_cmp++;
        if ({en, done, beat_cnt} !== {2'b01, 5'd1}) begin
            n_err++;
            $display("FAIL single_done: got en=%b done=%b cnt=%0d, want en=0 done=1 cnt=1", en, done, beat_cnt);
        end
        tick();
    endtask

    task automatic test_abort();
        ready = 1'b1;
        do_start(2'b00, 6'h20, 4'd3, 3'd0, 8'h00);
        tick();
        n_cmp++;
        if ({en, addr} !== {1'b1, 6'h21}) begin
            n_err++;
            $display("FAIL abort_pre: got en=%b addr=%h, want en=1 addr=21", en, addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if ({en, busy, done, beat_cnt} !== {3'b000, 5'd1}) begin
            n_err++;
            $display("FAIL abort_idle: got en=%b busy=%b done=%b cnt=%0d, want en=0 busy=0 done=0 cnt=1",
                     en, busy, done, beat_cnt);
        end
        tick();
        n_cmp++;
        if ({en, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_no_done: got en=%b busy=%b done=%b, want 000", en, busy, done);
        end
        // abort together with start in idle: stays idle.
        abort = 1'b1;
        do_start(2'b00, 6'h30, 4'd1, 3'd0, 8'h7F);
        abort = 1'b0;
        n_cmp++;
        if ({en, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_start: got en=%b busy=%b, want 00", en, busy);
        end
        do_start(2'b00, 6'h30, 4'd1, 3'd0, 8'h7F);
        n_cmp++;
        if ({en, busy, addr, wdata, beat_cnt} !== {2'b11, 6'h30, 8'h7F, 5'd0}) begin
            n_err++;
            $display("FAIL restart_beat0: got en=%b busy=%b addr=%h wdata=%h cnt=%0d, want en=1 busy=1 addr=30 wdata=7f cnt=0",
                     en, busy, addr, wdata, beat_cnt);
        end
        tick();
        n_cmp++;
        if ({en, addr, wdata} !== {1'b1, 6'h31, 8'h80}) begin
            n_err++;
            $display("FAIL restart_beat1: got en=%b addr=%h wdata=%h, want en=1 addr=31 wdata=80", en, addr, wdata);
        end
        tick();
        n_cmp++;
        if ({done, beat_cnt} !== {1'b1, 5'd2}) begin
            n_err++;
            $display("FAIL restart_done: got done=%b cnt=%0d, want done=1 cnt=2", done, beat_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        do_start(2'b00, 6'h01, 4'd3, 3'd3, 8'h40);
        tick();
        n_cmp++;
        if ({en, busy, beat_cnt} !== {2'b01, 5'd1}) begin
            n_err++;
            $display("FAIL rstmid_gap: got en=%b busy=%b cnt=%0d, want en=0 busy=1 cnt=1", en, busy, beat_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({addr, en, wr, wdata, busy, done, beat_cnt} !== 25'd0) begin
            n_err++;
            $display("FAIL rstmid_async: got addr=%h en=%b wr=%b wdata=%h busy=%b done=%b cnt=%0d, want all 0",
                     addr, en, wr, wdata, busy, done, beat_cnt);
        end
        start = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({addr, en, busy, done, beat_cnt} !== 14'd0) begin
            n_err++;
            $display("FAIL rstmid_start_ignored: got addr=%h en=%b busy=%b done=%b cnt=%0d, want all 0",
                     addr, en, busy, done, beat_cnt);
        end
        start = 1'b0;
        rst_n = 1'b1;
        do_start(2'b00, 6'h03, 4'd0, 3'd0, 8'h09);
        n_cmp++;
        if ({en, busy, addr, wdata} !== {2'b11, 6'h03, 8'h09}) begin
            n_err++;
            $display("FAIL rstmid_recover: got en=%b busy=%b addr=%h wdata=%h, want en=1 busy=1 addr=03 wdata=09",
                     en, busy, addr, wdata);
        end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_write_read();
        test_backpressure();
        test_alternate();
        test_max_len();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
